// File: rtl/lzd_denorm_shifter_if.sv
`default_nettype none
// ============================================================================
// lzd_denorm_shifter_if : input/output beat handshake bundle for lzd_denorm_shifter
// Rev 1.0
// ============================================================================
interface lzd_denorm_shifter_if #(
  parameter int W  = 16,
  parameter int SW = 4
);
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_mant;
  logic [SW-1:0] in_shamt;
  logic          in_nz;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_sticky;
  logic [SW-1:0] out_shamt;

  modport master (
    output in_valid, in_mant, in_shamt, in_nz, out_ready,
    input  in_ready, out_valid, out_data, out_sticky, out_shamt
  );

  modport slave (
    input  in_valid, in_mant, in_shamt, in_nz, out_ready,
    output in_ready, out_valid, out_data, out_sticky, out_shamt
  );
endinterface
`default_nettype wire

// File: rtl/lzd_denorm_shifter.sv
`default_nettype none
// ============================================================================
// lzd_denorm_shifter : 2-stage right barrel shifter with sticky, undoing LZD
// normalization. Define LZD_DENORM_RNE_EN for round-to-nearest-even output.
// Rev 1.0
// ============================================================================
module lzd_denorm_shifter #(
  parameter int W  = 16,
  parameter int SW = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  lzd_denorm_shifter_if.slave bus
);

  logic          s1_valid_q, s1_valid_d;
  logic [W-1:0]  s1_mant_q,  s1_mant_d;
  logic          s1_lo_q,    s1_lo_d;
  logic          s1_rbit_q,  s1_rbit_d;
  logic [SW-1:0] s1_shamt_q, s1_shamt_d;
  logic          s1_nz_q,    s1_nz_d;

  logic          out_valid_q,  out_valid_d;
  logic [W-1:0]  out_data_q,   out_data_d;
  logic          out_sticky_q, out_sticky_d;
  logic [SW-1:0] out_shamt_q,  out_shamt_d;

  logic s2_adv;
  logic s1_adv;

  assign s2_adv = !out_valid_q | bus.out_ready;
  assign s1_adv = !s1_valid_q | s2_adv;

  // Coarse stage: shift by a multiple of 4, keep the round bit separate from
  // the lower discarded bits so the fine stage can split r and s.
  logic [SW-1:0] coarse_amt;
  logic [W-1:0]  coarse_mant;
  logic          coarse_lo;
  logic          coarse_rbit;

  always_comb begin
    coarse_amt  = {bus.in_shamt[SW-1:2], 2'b00};
    coarse_mant = bus.in_mant >> coarse_amt;
    coarse_lo   = 1'b0;
    coarse_rbit = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (i + 1 < int'(coarse_amt))  coarse_lo   = coarse_lo | bus.in_mant[i];
      if (i + 1 == int'(coarse_amt)) coarse_rbit = bus.in_mant[i];
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_mant_d  = s1_mant_q;
    s1_lo_d    = s1_lo_q;
    s1_rbit_d  = s1_rbit_q;
    s1_shamt_d = s1_shamt_q;
    s1_nz_d    = s1_nz_q;
    if (s1_adv) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_mant_d  = coarse_mant;
        s1_lo_d    = coarse_lo;
        s1_rbit_d  = coarse_rbit;
        s1_shamt_d = bus.in_shamt;
        s1_nz_d    = bus.in_nz;
      end
    end
  end

  logic [1:0]   fine_amt;
  logic [W-1:0] fine_data;
  logic         fine_out;
  logic         raw_sticky;
  logic [W-1:0] result;
`ifdef LZD_DENORM_RNE_EN
  logic         rnd_r;
  logic         rnd_s;
  logic         rnd_inc;
`endif

  always_comb begin
    fine_amt  = s1_shamt_q[1:0];
    fine_data = s1_mant_q >> fine_amt;
    fine_out  = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (i < int'(fine_amt)) fine_out = fine_out | s1_mant_q[i];
    end
    raw_sticky = fine_out | s1_rbit_q | s1_lo_q;
`ifdef LZD_DENORM_RNE_EN
    rnd_r = 1'b0;
    rnd_s = s1_lo_q;
    if (fine_amt == 2'd0) rnd_r = s1_rbit_q;
    else                  rnd_s = rnd_s | s1_rbit_q;
    for (int i = 0; i < W; i++) begin
      if (i + 1 == int'(fine_amt)) rnd_r = s1_mant_q[i];
      if (i + 1 < int'(fine_amt))  rnd_s = rnd_s | s1_mant_q[i];
    end
    // shamt=0 leaves r=0, and any shamt>=1 frees the MSB, so no overflow.
    rnd_inc = rnd_r & (rnd_s | fine_data[0]);
    result  = fine_data + {{(W-1){1'b0}}, rnd_inc};
`else
    result = fine_data;
`endif
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_sticky_d = out_sticky_q;
    out_shamt_d  = out_shamt_q;
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d   = s1_nz_q ? result : '0;
        out_sticky_d = s1_nz_q & raw_sticky;
        out_shamt_d  = s1_shamt_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_mant_q    <= '0;
      s1_lo_q      <= 1'b0;
      s1_rbit_q    <= 1'b0;
      s1_shamt_q   <= '0;
      s1_nz_q      <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_sticky_q <= 1'b0;
      out_shamt_q  <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_mant_q    <= s1_mant_d;
      s1_lo_q      <= s1_lo_d;
      s1_rbit_q    <= s1_rbit_d;
      s1_shamt_q   <= s1_shamt_d;
      s1_nz_q      <= s1_nz_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_sticky_q <= out_sticky_d;
      out_shamt_q  <= out_shamt_d;
    end
  end

  assign bus.in_ready   = s1_adv;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_sticky = out_sticky_q;
  assign bus.out_shamt  = out_shamt_q;

endmodule
`default_nettype wire

// File: tb/tb_lzd_denorm_shifter.sv
`default_nettype none
// Randomized and directed check of lzd_denorm_shifter against an arithmetic
// reference (mantissa placed in a 2W window and shifted right).
module tb_lzd_denorm_shifter;
  localparam int W  = 16;
  localparam int SW = 4;

  typedef struct packed {
    logic [W-1:0]  data;
    logic          sticky;
    logic [SW-1:0] shamt;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  lzd_denorm_shifter_if #(.W(W), .SW(SW)) bus ();

  lzd_denorm_shifter #(.W(W), .SW(SW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  exp_t          exp_q[$];
  int            n_total    = 0;
  int            n_bad      = 0;
  int            cyc        = 0;
  int            acc_cnt    = 0;
  int            del_cnt    = 0;
  int            ready_mode = 0;
  logic          prev_stall = 1'b0;
  logic [W-1:0]  prev_data  = '0;
  logic          prev_sticky = 1'b0;
  logic [SW-1:0] prev_shamt = '0;

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // out_ready policy: 0 = always ready, 1 = random, 2 = stalled
  initial forever begin
    @(posedge clk);
    #2;
    case (ready_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = ($urandom_range(0, 3) != 0);
      default: bus.out_ready = 1'b0;
    endcase
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t ref_model(input logic [W-1:0] m, input logic [SW-1:0] sh, input logic nz);
    logic [2*W-1:0] full;
    exp_t e;
    full     = {m, {W{1'b0}}} >> sh;
    e.data   = full[2*W-1:W];
    e.sticky = |full[W-1:0];
    e.shamt  = sh;
`ifdef LZD_DENORM_RNE_EN
    if (full[W-1] && ((|full[W-2:0]) || full[W]))
      e.data = e.data + {{(W-1){1'b0}}, 1'b1};
`endif
    if (!nz) begin
      e.data   = '0;
      e.sticky = 1'b0;
    end
    return e;
  endfunction

  function automatic exp_t mk(input logic [W-1:0] d, input logic s, input logic [SW-1:0] sh);
    exp_t e;
    e.data   = d;
    e.sticky = s;
    e.shamt  = sh;
    return e;
  endfunction

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic drive_beat(input logic [W-1:0] m, input logic [SW-1:0] sh, input logic nz, input exp_t e);
    logic done;
    done         = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_mant  = m;
    bus.in_shamt = sh;
    bus.in_nz    = nz;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        exp_q.push_back(e);
        done = 1'b1;
      end
    end
    if (!done) check_eq("accept_timeout", {31'd0, done}, 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_rand(input logic [W-1:0] m, input logic [SW-1:0] sh, input logic nz);
    drive_beat(m, sh, nz, ref_model(m, sh, nz));
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.out_valid) break;
    end
    check_eq("drain", exp_q.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard and stall-stability monitor
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check_eq("hold_valid",  {31'd0, bus.out_valid}, 32'd1);
        check_eq("hold_data",   {16'd0, bus.out_data}, {16'd0, prev_data});
        check_eq("hold_sticky", {31'd0, bus.out_sticky}, {31'd0, prev_sticky});
        check_eq("hold_shamt",  {28'd0, bus.out_shamt}, {28'd0, prev_shamt});
      end
      if (bus.in_valid && bus.in_ready) acc_cnt++;
      if (bus.out_valid && bus.out_ready) begin
        del_cnt++;
        if (exp_q.size() == 0) begin
          check_eq("unexpected_beat", exp_q.size(), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check_eq("data",   {16'd0, bus.out_data}, {16'd0, e.data});
          check_eq("sticky", {31'd0, bus.out_sticky}, {31'd0, e.sticky});
          check_eq("shamt",  {28'd0, bus.out_shamt}, {28'd0, e.shamt});
        end
      end
      prev_stall  = bus.out_valid && !bus.out_ready;
      prev_data   = bus.out_data;
      prev_sticky = bus.out_sticky;
      prev_shamt  = bus.out_shamt;
    end
  end

  initial begin
    int c0;
    int a0;
    int d0;
    logic [W-1:0]  m;
    logic [SW-1:0] sh;
    logic          nz;

    bus.in_valid  = 1'b0;
    bus.in_mant   = '0;
    bus.in_shamt  = '0;
    bus.in_nz     = 1'b0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out_valid",  {31'd0, bus.out_valid}, 32'd0);
    check_eq("rst_in_ready",   {31'd0, bus.in_ready}, 32'd1);
    check_eq("rst_out_data",   {16'd0, bus.out_data}, 32'd0);
    check_eq("rst_out_sticky", {31'd0, bus.out_sticky}, 32'd0);
    check_eq("rst_out_shamt",  {28'd0, bus.out_shamt}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic shift and 2-cycle latency
    drive_beat(16'hB400, 4'd3, 1'b1, mk(16'h1680, 1'b0, 4'd3));
    @(negedge clk);
    check_eq("lat_c1", {31'd0, bus.out_valid}, 32'd0);
    @(negedge clk);
    check_eq("lat_c2", {31'd0, bus.out_valid}, 32'd1);
    @(posedge clk);
    #1;

    // Boundary and rounding vectors
`ifdef LZD_DENORM_RNE_EN
    drive_beat(16'hFFFF, 4'd15, 1'b1, mk(16'h0002, 1'b1, 4'd15));
    drive_beat(16'h8003, 4'd1,  1'b1, mk(16'h4002, 1'b1, 4'd1));
`else
    drive_beat(16'hFFFF, 4'd15, 1'b1, mk(16'h0001, 1'b1, 4'd15));
    drive_beat(16'h8003, 4'd1,  1'b1, mk(16'h4001, 1'b1, 4'd1));
`endif
    drive_beat(16'h8001, 4'd1,  1'b1, mk(16'h4000, 1'b1, 4'd1));
    drive_beat(16'hFFFF, 4'd0,  1'b0, mk(16'h0000, 1'b0, 4'd0));
    drive_beat(16'h1234, 4'd0,  1'b1, mk(16'h1234, 1'b0, 4'd0));
    drive_beat(16'h8000, 4'd15, 1'b1, mk(16'h0001, 1'b0, 4'd15));
    wait_drain();

    // Full throughput: 8 beats in 8 cycles
    c0 = cyc;
    for (int k = 0; k < 8; k++) send_rand(W'($urandom()), SW'($urandom_range(0, 15)), 1'b1);
    check_eq("throughput_cycles", cyc - c0, 32'd8);
    wait_drain();

    // Backpressure: 5 beats against a stalled output
    ready_mode = 2;
    @(posedge clk);
    #1;
    a0 = acc_cnt;
    d0 = del_cnt;
    fork
      begin
        for (int k = 0; k < 5; k++) send_rand(W'($urandom()), SW'($urandom_range(0, 15)), 1'b1);
      end
      begin
        repeat (6) @(negedge clk);
        check_eq("bp_accepted", acc_cnt - a0, 32'd2);
        check_eq("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
        ready_mode = 0;
      end
    join
    wait_drain();
    check_eq("bp_delivered", del_cnt - d0, 32'd5);

    // Random stream with random backpressure and gaps
    ready_mode = 1;
    for (int k = 0; k < 300; k++) begin
      case ($urandom_range(0, 3))
        0:       m = 16'hFFFF;
        1:       m = 16'h8000 | W'($urandom());
        default: m = W'($urandom());
      endcase
      sh = SW'($urandom_range(0, 15));
      nz = ($urandom_range(0, 7) != 0);
      send_rand(m, sh, nz);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    ready_mode = 0;
    wait_drain();

    // Asynchronous reset with both stages full
    ready_mode = 2;
    @(posedge clk);
    #1;
    send_rand(16'hA5A5, 4'd5, 1'b1);
    send_rand(16'h5A5A, 4'd9, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check_eq("mid_rst_out_data",  {16'd0, bus.out_data}, 32'd0);
    check_eq("mid_rst_in_ready",  {31'd0, bus.in_ready}, 32'd1);
    exp_q.delete();
    ready_mode = 0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_rand(16'hC3F1, 4'd6, 1'b1);
    @(negedge clk);
    check_eq("post_rst_lat_c1", {31'd0, bus.out_valid}, 32'd0);
    @(negedge clk);
    check_eq("post_rst_lat_c2", {31'd0, bus.out_valid}, 32'd1);
    @(posedge clk);
    #1;
    wait_drain();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lzd_denorm_shifter.md
Name: lzd_denorm_shifter

Overview:
- Inverse companion to the 16-bit leading-zero detector in the Box-Muller AWGN datapath.
- Takes a normalized mantissa plus the 4-bit position/shift code that the LZD produced, and re-expands it by right-shifting back to fixed-point alignment.
- Reports a sticky bit for the shifted-out bits.
- 2-stage pipelined barrel shifter with valid/ready handshakes on both sides; sits between the log/sqrt normalized datapath and the fixed-point output stage.

Parameters:
- W, 16, mantissa/data width.
- SW, 4, shift-code width; equals log2(W).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat this cycle
- in_mant  in  W  normalized mantissa
- in_shamt  in  SW  right-shift amount, 0..W-1
- in_nz  in  1  mantissa non-zero flag (LZD v output); 0 forces zero result
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts beat
- out_data  out  W  shifted (optionally rounded) result
- out_sticky  out  1  OR of all bits shifted out
- out_shamt  out  SW  shift amount carried through, for exponent bookkeeping

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: in_ready=1, out_valid=0, out_data=0, out_sticky=0, out_shamt=0, all internal valids=0. Reset mid-operation discards in-flight beats.
- Transfer rules:
  - A beat is accepted when in_valid & in_ready on a rising edge.
  - A beat is delivered when out_valid & out_ready.
- Stage 1 (S1) registers:
  - mant >> (4*shamt[3:2]), i.e. coarse shift by 0/4/8/12.
  - OR of the coarse-shifted-out bits.
  - The bit just below the coarse result (kept for rounding).
  - shamt, and nz.
- Stage 2 (S2 = output registers):
  - Fine shift by shamt[1:0].
  - sticky = OR of every input bit below bit position shamt.
  - If nz=0: out_data=0, out_sticky=0, regardless of in_mant.
- Latency: 2 cycles from acceptance to out_valid with no backpressure. Throughput is 1 beat/cycle.
- Advance rules:
  - s2_adv = !out_valid | out_ready
  - s1_adv = !s1_valid | s2_adv
  - in_ready = s1_adv (combinational from out_ready, no skid buffer).
- Stall: when out_valid & !out_ready, S2 holds. S1 holds if it is full. in_ready drops only when both stages are full.
- Simultaneous accept at input and delivery at output in one cycle is legal; there are no bubbles.
- Outputs must remain stable while out_valid & !out_ready.
- shamt=0: out_data=in_mant, sticky=0.
- shamt=W-1: out_data = in_mant[W-1] only.
- Shift is logical: zeros fill from the MSB.

Optional Feature:
- Macro: LZD_DENORM_RNE_EN.
- Defined: out_data is rounded to nearest-even.
  - round bit r = bit just below the result LSB; s = OR of the lower discarded bits.
  - Increment when r & (s | lsb).
  - out_sticky still reports the raw OR of all discarded bits.
  - The increment cannot overflow W bits for shamt≥1. shamt=0 never rounds.
- Undefined: truncation; out_data is the pure shifted value. The rounding logic is absent.
- Latency is 2 cycles in both builds.

Test Plan:
- Reset: assert rst_n=0 mid-stream with beats in both stages -> out_valid=0, out_data=0, in_ready=1 immediately (async). The first beat after release appears 2 cycles after acceptance.
- Basic shift: mant=0xB400, shamt=3, nz=1 -> out_data=0x1680, sticky=0, out_shamt=3, 2 cycles later.
- Sticky/round: mant=0xFFFF, shamt=15 -> sticky=1. out_data=0x0001 without RNE; 0x0002 with LZD_DENORM_RNE_EN.
- Ties-to-even: mant=0x8001, shamt=1 -> 0x4000 in both builds (tie, lsb even). mant=0x8003, shamt=1 -> 0x4001 truncated, 0x4002 with RNE.
- Zero flag: mant=0xFFFF, shamt=0, nz=0 -> out_data=0x0000, sticky=0.
- Backpressure: stream 5 beats back-to-back with out_ready held low for 4 cycles ->
  - in_ready falls after 2 accepted beats.
  - out_data is held constant while stalled.
  - All 5 beats are delivered in order with no loss or duplication once out_ready=1.
  - Full throughput is 1 beat/cycle.
